// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the encoder and the scan decoder,
// so both ends of a display loopback agree on one pattern table.
package seg7_pkg;

    // Bit positions of each segment within a 7-bit pattern (a is the MSB).
    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        StWait,
        StCaptured
    } scan_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder; anything outside the
// ten digit patterns (blank included) is reported as illegal and decodes to 0.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       legal
);

    always_comb begin
        bcd   = 4'd0;
        legal = 1'b1;
        unique case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Captures stable digits from a multiplexed 7-segment bus, decodes them to BCD
// and publishes a full multi-digit value once every position has been seen.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    digit_err,
    output logic [2:0]              err_idx
);

    localparam int unsigned SW = NUM_DIGITS + 7;

    logic [SW-1:0]           samp_q, samp_d;
    logic [3:0]              cnt_q, cnt_d;
    scan_state_e             state_q, state_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    digit_err_q, digit_err_d;
    logic [2:0]              err_idx_q, err_idx_d;

    logic [NUM_DIGITS-1:0] s_dig;
    logic [6:0]            s_seg;
    logic [3:0]            dec_bcd;
    logic                  dec_legal;
    logic                  same;
    logic                  one_hot;
    logic                  cap_evt;
    logic [2:0]            dig_idx;
    logic [NUM_DIGITS-1:0] mask_new;

    assign samp_d = {dig_en, seg_in};
    assign s_dig  = samp_q[SW-1:7];
    assign s_seg  = samp_q[6:0];

    // Only the registered sample is decoded; raw inputs never reach the decoder.
    seg7_to_bcd u_seg7_to_bcd (
        .seg   (s_seg),
        .bcd   (dec_bcd),
        .legal (dec_legal)
    );

    assign same     = (samp_d == samp_q);
    assign one_hot  = (s_dig != '0) && ((s_dig & (s_dig - NUM_DIGITS'(1))) == '0);
    assign cap_evt  = same && (cnt_q == 4'(STABLE_CYCLES - 1)) && one_hot
                      && (state_q == StWait);
    assign mask_new = mask_q | s_dig;

    always_comb begin
        dig_idx = 3'd0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s_dig[i]) begin
                dig_idx = 3'(i);
            end
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        state_d       = state_q;
        mask_d        = mask_q;
        shadow_d      = shadow_q;
        bcd_d         = bcd_q;
        frame_valid_d = 1'b0;
        digit_err_d   = 1'b0;
        err_idx_d     = err_idx_q;

        if (!same) begin
            cnt_d = 4'd0;
        end else if (cnt_q < 4'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 4'd1;
        end

        unique case (state_q)
            StWait: begin
                if (cap_evt) begin
                    state_d = StCaptured;
                end
            end
            StCaptured: begin
                if (!same) begin
                    state_d = StWait;
                end
            end
            default: state_d = StWait;
        endcase

        if (cap_evt) begin
            if (dec_legal) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (s_dig[i]) begin
                        shadow_d[4*i +: 4] = dec_bcd;
                    end
                end
                // Publish includes the nibble captured on this same edge.
                if (&mask_new) begin
                    bcd_d         = shadow_d;
                    frame_valid_d = 1'b1;
                    mask_d        = '0;
                end else begin
                    mask_d = mask_new;
                end
            end else begin
                digit_err_d = 1'b1;
                err_idx_d   = dig_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q        <= '0;
            cnt_q         <= 4'd0;
            state_q       <= StWait;
            mask_q        <= '0;
            shadow_q      <= '0;
            bcd_q         <= '0;
            frame_valid_q <= 1'b0;
            digit_err_q   <= 1'b0;
            err_idx_q     <= 3'd0;
        end else begin
            samp_q        <= samp_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            bcd_q         <= bcd_d;
            frame_valid_q <= frame_valid_d;
            digit_err_q   <= digit_err_d;
            err_idx_q     <= err_idx_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = frame_valid_q;
    assign digit_err   = digit_err_q;
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        digit_err;
    logic [2:0]  err_idx;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0;
    int de_cnt = 0;
    int both_cnt = 0;
    int fv_base;
    int de_base;

    seg7_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .bcd_out     (bcd_out),
        .frame_valid (frame_valid),
        .digit_err   (digit_err),
        .err_idx     (err_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (digit_err) de_cnt++;
        if (frame_valid && digit_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a value so that exactly n rising edges register it.
    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        @(negedge clk);
        dig_en = d;
        seg_in = s;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic put_digit(input logic [3:0] d, input logic [6:0] s);
        hold(d, s, 6);
        hold(4'b0000, 7'b0000000, 2);
    endtask

    task automatic mark();
        fv_base = fv_cnt;
        de_base = de_cnt;
    endtask

    initial begin
        rst    = 1'b1;
        dig_en = 4'b0000;
        seg_in = 7'b0000000;
        repeat (2) @(negedge clk);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_fv", 16'(frame_valid), 16'h0);
        check("rst_de", 16'(digit_err), 16'h0);
        check("rst_eidx", 16'(err_idx), 16'h0);
        rst = 1'b0;
        hold(4'b0000, 7'b0000000, 3);

        // Full frame 8153, with cycle-exact timing on the last digit.
        mark();
        put_digit(4'b0001, 7'b1111001);
        put_digit(4'b0010, 7'b1011011);
        put_digit(4'b0100, 7'b0110000);
        check("ff_partial_bcd", bcd_out, 16'h0000);
        @(negedge clk);
        dig_en = 4'b1000;
        seg_in = 7'b1111111;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            check($sformatf("ff_fv_edge%0d", e), 16'(frame_valid), (e == 5) ? 16'h1 : 16'h0);
        end
        hold(4'b0000, 7'b0000000, 2);
        check("ff_bcd", bcd_out, 16'h8153);
        check("ff_fv_count", 16'(fv_cnt - fv_base), 16'd1);
        check("ff_de_count", 16'(de_cnt - de_base), 16'd0);

        // Glitch on digit 0, then a too-short hold on digit 3.
        mark();
        hold(4'b0001, 7'b1111110, 3);
        hold(4'b0001, 7'b1110000, 5);
        hold(4'b0000, 7'b0000000, 2);
        put_digit(4'b0010, 7'b1101101);
        put_digit(4'b0100, 7'b1011111);
        hold(4'b1000, 7'b0110000, 4);
        hold(4'b0000, 7'b0000000, 2);
        check("short_no_fv", 16'(fv_cnt - fv_base), 16'd0);
        check("short_bcd", bcd_out, 16'h8153);
        put_digit(4'b1000, 7'b1111011);
        check("glitch_bcd", bcd_out, 16'h9627);
        check("glitch_fv_count", 16'(fv_cnt - fv_base), 16'd1);

        // Illegal pattern on digit 2, then a legal frame.
        mark();
        put_digit(4'b0100, 7'b0000001);
        check("ill_de_count", 16'(de_cnt - de_base), 16'd1);
        check("ill_eidx", 16'(err_idx), 16'd2);
        check("ill_no_fv", 16'(fv_cnt - fv_base), 16'd0);
        check("ill_bcd", bcd_out, 16'h9627);
        put_digit(4'b0001, 7'b0110000);
        put_digit(4'b0010, 7'b1111001);
        put_digit(4'b0100, 7'b0110011);
        put_digit(4'b1000, 7'b1011011);
        check("ill_frame_bcd", bcd_out, 16'h5431);
        check("ill_frame_fv", 16'(fv_cnt - fv_base), 16'd1);
        check("ill_eidx_held", 16'(err_idx), 16'd2);

        // Non-one-hot selects must leave the mask alone.
        mark();
        hold(4'b0011, 7'b1111110, 10);
        hold(4'b0000, 7'b0110000, 10);
        check("noh_fv", 16'(fv_cnt - fv_base), 16'd0);
        check("noh_de", 16'(de_cnt - de_base), 16'd0);
        check("noh_bcd", bcd_out, 16'h5431);
        put_digit(4'b0010, 7'b1111110);
        put_digit(4'b0100, 7'b1110000);
        put_digit(4'b1000, 7'b1011111);
        check("noh_mask_fv", 16'(fv_cnt - fv_base), 16'd0);
        put_digit(4'b0001, 7'b1101101);
        check("noh_frame_bcd", bcd_out, 16'h6702);
        check("noh_frame_fv", 16'(fv_cnt - fv_base), 16'd1);

        // Reset mid-frame discards partial capture.
        mark();
        put_digit(4'b0001, 7'b1111111);
        put_digit(4'b0010, 7'b1111111);
        put_digit(4'b0100, 7'b1111111);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_bcd", bcd_out, 16'h0000);
        check("mrst_eidx", 16'(err_idx), 16'd0);
        put_digit(4'b1000, 7'b1111001);
        check("mrst_no_fv", 16'(fv_cnt - fv_base), 16'd0);
        check("mrst_bcd_hold", bcd_out, 16'h0000);
        put_digit(4'b0001, 7'b0110000);
        put_digit(4'b0010, 7'b1111011);
        put_digit(4'b0100, 7'b1011011);
        check("mrst_frame_bcd", bcd_out, 16'h3591);
        check("mrst_frame_fv", 16'(fv_cnt - fv_base), 16'd1);

        check("fv_de_exclusive", 16'(both_cnt), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
